// File: rtl/memory_bus_arbiter_if.sv
// Processor-side request/grant bus and single memory port of the shared data memory arbiter.
// The master view belongs to the arbiter. The slave view belongs to the processors and the memory together.
interface memory_bus_arbiter_if #(
    parameter int WORD_SIZE            = 32,
    parameter int NUMBER_OF_PROCESSORS = 4,
    parameter int ADDRESS_WIDTH        = 10
);
    localparam int OWNER_WIDTH = (NUMBER_OF_PROCESSORS > 1) ? $clog2(NUMBER_OF_PROCESSORS) : 1;

    logic [NUMBER_OF_PROCESSORS-1:0]               requests;
    logic [NUMBER_OF_PROCESSORS*ADDRESS_WIDTH-1:0] addresses;
    logic [NUMBER_OF_PROCESSORS*WORD_SIZE-1:0]     write_data;
    logic [NUMBER_OF_PROCESSORS-1:0]               read_enables;
    logic [NUMBER_OF_PROCESSORS-1:0]               write_enables;

    logic [NUMBER_OF_PROCESSORS-1:0]               grants;
    logic [ADDRESS_WIDTH-1:0]                      memory_address;
    logic [WORD_SIZE-1:0]                          memory_write_data;
    logic                                          memory_read_enable;
    logic                                          memory_write_enable;
    logic [OWNER_WIDTH-1:0]                        owner;
    logic                                          timeout;

    modport master (
        input  requests, addresses, write_data, read_enables, write_enables,
        output grants, memory_address, memory_write_data,
               memory_read_enable, memory_write_enable, owner, timeout
    );

    modport slave (
        output requests, addresses, write_data, read_enables, write_enables,
        input  grants, memory_address, memory_write_data,
               memory_read_enable, memory_write_enable, owner, timeout
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter and bus multiplexer from N processors onto one memory port.
// Grants are held for a whole burst, with a hold watchdog and a one-cycle turnaround gap.
module memory_bus_arbiter #(
    parameter int WORD_SIZE            = 32,
    parameter int NUMBER_OF_PROCESSORS = 4,
    parameter int ADDRESS_WIDTH        = 10,
    parameter int MAX_HOLD             = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    memory_bus_arbiter_if.master bus
);
    localparam int N           = NUMBER_OF_PROCESSORS;
    localparam int OWNER_WIDTH = (N > 1) ? $clog2(N) : 1;
    localparam int HOLD_WIDTH  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [HOLD_WIDTH-1:0]  HOLD_LAST      = (MAX_HOLD > 1) ? HOLD_WIDTH'(MAX_HOLD - 1) : '0;
    localparam logic [OWNER_WIDTH-1:0] LAST_PROCESSOR = OWNER_WIDTH'(N - 1);
    localparam logic [N-1:0]           GRANT_ONE      = N'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [OWNER_WIDTH-1:0]  owner_reg, owner_next;
    logic [N-1:0]            grants_reg, grants_next;
    logic                    timeout_reg, timeout_next;
    logic [HOLD_WIDTH-1:0]   hold_reg, hold_next;

    logic [OWNER_WIDTH-1:0]  winner;
    logic [OWNER_WIDTH-1:0]  candidate;
    logic                    any_request;
    logic                    owner_request;
    logic                    hold_expired;
    logic                    bus_granted;

    logic [ADDRESS_WIDTH-1:0] address_array [N];
    logic [WORD_SIZE-1:0]     data_array    [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign address_array[gi] = bus.addresses[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign data_array[gi]    = bus.write_data[gi*WORD_SIZE +: WORD_SIZE];
        end
    endgenerate

    assign any_request   = |bus.requests;
    assign owner_request = bus.requests[owner_reg];
    assign hold_expired  = (MAX_HOLD != 0) && (hold_reg == HOLD_LAST);

    // Scan from owner+1 upward with wrap; walking distances downward lets the nearest one win.
    always_comb begin
        winner    = owner_reg;
        candidate = owner_reg;
        for (int k = N; k >= 1; k--) begin
            candidate = OWNER_WIDTH'((int'(owner_reg) + k) % N);
            if (bus.requests[candidate]) begin
                winner = candidate;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= LAST_PROCESSOR;
            grants_reg  <= '0;
            timeout_reg <= 1'b0;
            hold_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            grants_reg  <= grants_next;
            timeout_reg <= timeout_next;
            hold_reg    <= hold_next;
        end
    end

    // The edge leaving the gap is itself an arbitration edge, so back-to-back bursts lose one cycle.
    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        grants_next  = grants_reg;
        timeout_next = 1'b0;
        hold_next    = hold_reg;
        unique case (state_reg)
            ST_IDLE, ST_GAP: begin
                grants_next = '0;
                if (any_request) begin
                    state_next  = ST_GRANT;
                    owner_next  = winner;
                    grants_next = GRANT_ONE << winner;
                    hold_next   = '0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!owner_request) begin
                    state_next  = ST_GAP;
                    grants_next = '0;
                end else if (hold_expired) begin
                    state_next   = ST_GAP;
                    grants_next  = '0;
                    timeout_next = 1'b1;
                end else if (hold_reg != HOLD_LAST) begin
                    hold_next = hold_reg + HOLD_WIDTH'(1);
                end
            end
            default: begin
                state_next  = ST_IDLE;
                grants_next = '0;
            end
        endcase
    end

    // Memory port follows the owner only while granted; reset drops the enables without waiting for a clock.
    assign bus_granted             = (state_reg == ST_GRANT) && grants_reg[owner_reg];
    assign bus.memory_address      = bus_granted ? address_array[owner_reg] : '0;
    assign bus.memory_write_data   = bus_granted ? data_array[owner_reg] : '0;
    assign bus.memory_read_enable  = bus_granted && bus.read_enables[owner_reg];
    assign bus.memory_write_enable = bus_granted && bus.write_enables[owner_reg];

    assign bus.grants  = grants_reg;
    assign bus.owner   = owner_reg;
    assign bus.timeout = timeout_reg;
endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Round-robin arbiter and bus multiplexer between the processing units and the shared data memory of the matrix-multiplication coprocessor. Each processor raises a request, receives an exclusive grant, and drives address, data and enables through this block to the single memory port. Grants are held for the whole burst, so a block fetch or write-back is never interleaved. Rotating priority and a hold watchdog keep any processor from being starved.

## Interface
- WORD_SIZE, 32, memory data width
- NUMBER_OF_PROCESSORS, 4, requester count N (≥2)
- ADDRESS_WIDTH, 10, memory address width (1024 words)
- MAX_HOLD, 64, maximum consecutive granted cycles per burst; 0 disables the watchdog

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_Requests  in  N  per-processor bus request, level, held for the whole burst
- i_Addresses  in  N*ADDRESS_WIDTH  per-processor address; processor p at bits [p*AW +: AW]
- i_Write_Data  in  N*WORD_SIZE  per-processor write data, same packing
- i_Read_Enables  in  N  per-processor read strobe
- i_Write_Enables  in  N  per-processor write strobe
- o_Grants  out  N  one-hot grant, registered
- o_Memory_Address  out  ADDRESS_WIDTH  to memory
- o_Memory_Write_Data  out  WORD_SIZE  to memory
- o_Memory_Read_Enable  out  1  to memory
- o_Memory_Write_Enable  out  1  to memory
- o_Owner  out  clog2(N)  index of the current or last owner, registered
- o_Timeout  out  1  one-cycle pulse when the watchdog revokes a grant

## Operation
- States: IDLE, GRANT, GAP.
- IDLE: o_Grants = 0. At a rising edge with any request set, pick the first set request scanning from (o_Owner+1) mod N upward with wrap. Load o_Owner, set the one-hot grant, clear the hold counter, go to GRANT. With no request set, stay in IDLE.
- GRANT: o_Grants holds the owner bit.
  - If the owner's request is low at an edge: go to GAP.
  - Otherwise, if MAX_HOLD≠0 and the hold counter is MAX_HOLD−1: go to GAP and pulse o_Timeout for exactly one cycle.
  - Otherwise the counter increments, saturating at MAX_HOLD−1.
- GAP: o_Grants = 0 for exactly one cycle of bus turnaround, then IDLE. A new arbitration happens at the IDLE edge.
- Memory-side outputs are combinational from the owner's inputs, and only in GRANT.
  - Address and write data pass through.
  - Each enable is the owner's enable AND grant.
  - In IDLE and GAP: both enables 0, address 0, write data 0.
- Non-owner enables are ignored. No error is flagged for them.
- Simultaneous read and write from the owner are both forwarded. Resolving them is the memory's responsibility.
- A processor whose burst was revoked must re-request. It now has lowest priority.
- Reset (asynchronous, at any time, including mid-burst):
  - State goes to IDLE; o_Grants, o_Timeout and the hold counter go to 0.
  - o_Owner goes to N−1, so processor 0 wins the first arbitration.
  - Memory enables fall immediately (combinational).

## Timing
- Request-to-grant latency: a request visible before edge k, with the block in IDLE, gives a grant high after edge k. The processor can drive its first access in that cycle.
- Release: the owner drops its request before edge k. The grant falls after edge k (GAP). The earliest next grant is after edge k+1.
- Back-to-back bursts therefore have one dead bus cycle between grants.
- A burst of L accesses holding request for L cycles occupies L+2 cycles including the gap.
- Watchdog: the grant lasts at most MAX_HOLD cycles. o_Timeout is high in the GAP cycle that follows.
- All outputs except the memory-side bus are registered.

## Test plan
- Reset, then i_Requests=4'b1111 held with each processor releasing after 3 granted cycles -> grants in order 0,1,2,3,0; each grant high 3 cycles; exactly one zero-grant cycle between grants.
- Owner 2 writing: Write_Data=0xDEADBEEF, address 0x005; processor 1 also asserts write enable to 0x3FF -> memory sees only 0x005/0xDEADBEEF with write enable; processor 1 is ignored until granted.
- Single request from processor 3 while idle -> grant 4'b1000 after the next edge; o_Owner=3; memory enables track processor 3 only while granted.
- MAX_HOLD=4, processor 1 holds its request indefinitely while 2 also requests:
  - grant 1 lasts exactly 4 cycles;
  - o_Timeout pulses once in the following GAP;
  - processor 2 is granted next.
- Reset asserted mid-burst with processor 1 owner -> o_Grants=0 and memory enables 0 immediately; after release with all requesting, processor 0 wins first.
- No requests for 20 cycles -> o_Grants=0, memory enables 0, o_Owner unchanged, no o_Timeout.
